// File: rtl/rv32_fetch_queue.sv
// Decoupled RV32 fetch: in-order imem request/response with bounded in-flight requests and an instruction queue.
// Optional feature: define RV32_FETCH_BYPASS_EN to let a response load decode directly when the queue is empty.
module rv32_fetch_queue #(
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            pc_source_i,
  input  logic [31:0]                     pc_target_i,
  input  logic                            stall_f_i,
  input  logic                            stall_d_i,
  input  logic                            flush_d_i,
  output logic                            imem_req_o,
  output logic [31:0]                     imem_addr_o,
  input  logic                            imem_gnt_i,
  input  logic                            imem_rvalid_i,
  input  logic [31:0]                     imem_rdata_i,
  output logic [31:0]                     instr_o,
  output logic [31:0]                     pc_o,
  output logic [31:0]                     pc_next_o,
  output logic                            instr_valid_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count_o
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned QW = $clog2(FIFO_DEPTH);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic          run_reg;
  logic [31:0]   pc_reg;
  logic [OW-1:0] outstanding_reg;
  logic [OW-1:0] discard_reg;
  logic [TW-1:0] trk_wr_reg;
  logic [TW-1:0] trk_rd_reg;
  logic [31:0]   trk_mem [MAX_OUTSTANDING];
  logic [QW-1:0] q_wr_reg;
  logic [QW-1:0] q_rd_reg;
  logic [CW-1:0] count_reg;
  logic [31:0]   q_pc_mem    [FIFO_DEPTH];
  logic [31:0]   q_instr_mem [FIFO_DEPTH];
  logic [31:0]   instr_reg;
  logic [31:0]   pc_d_reg;
  logic [31:0]   pc_next_reg;
  logic          valid_reg;

  logic [31:0] credit_used;
  logic [31:0] resp_pc;
  logic        grant;
  logic        keep;
  logic        dec_load;
  logic        pop;
  logic        push;
  logic        bypass;

  function automatic logic [TW-1:0] trk_inc(input logic [TW-1:0] p);
    return (32'(p) == MAX_OUTSTANDING - 1) ? '0 : p + TW'(1);
  endfunction

  // Credits cover both queued entries and requests whose responses will still land in the queue.
  assign credit_used = 32'(outstanding_reg) + 32'(count_reg);
  assign imem_req_o  = run_reg && !stall_f_i && !pc_source_i &&
                       (32'(outstanding_reg) < MAX_OUTSTANDING) &&
                       (credit_used < FIFO_DEPTH);
  assign imem_addr_o = pc_reg;
  assign grant       = imem_req_o && imem_gnt_i;
  assign resp_pc     = trk_mem[trk_rd_reg];
  assign keep        = imem_rvalid_i && (discard_reg == '0) && !pc_source_i;
  assign dec_load    = !flush_d_i && !stall_d_i && !pc_source_i;
  assign pop         = dec_load && (count_reg != '0);
`ifdef RV32_FETCH_BYPASS_EN
  assign bypass      = keep && dec_load && (count_reg == '0);
`else
  assign bypass      = 1'b0;
`endif
  assign push        = keep && !bypass;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      run_reg         <= 1'b0;
      pc_reg          <= RESET_PC;
      outstanding_reg <= '0;
      discard_reg     <= '0;
      trk_wr_reg      <= '0;
      trk_rd_reg      <= '0;
      q_wr_reg        <= '0;
      q_rd_reg        <= '0;
      count_reg       <= '0;
      instr_reg       <= '0;
      pc_d_reg        <= '0;
      pc_next_reg     <= '0;
      valid_reg       <= 1'b0;
    end else begin
      run_reg <= 1'b1;
      if (pc_source_i)
        pc_reg <= pc_target_i;
      else if (grant)
        pc_reg <= pc_reg + 32'd4;

      if (grant)
        trk_wr_reg <= trk_inc(trk_wr_reg);
      if (imem_rvalid_i)
        trk_rd_reg <= trk_inc(trk_rd_reg);
      outstanding_reg <= outstanding_reg + OW'(grant) - OW'(imem_rvalid_i);

      // Everything still in flight after a redirect belongs to the old path.
      if (pc_source_i)
        discard_reg <= outstanding_reg - OW'(imem_rvalid_i);
      else if (imem_rvalid_i && (discard_reg != '0))
        discard_reg <= discard_reg - OW'(1);

      if (pc_source_i) begin
        q_wr_reg  <= '0;
        q_rd_reg  <= '0;
        count_reg <= '0;
      end else begin
        if (push)
          q_wr_reg <= q_wr_reg + QW'(1);
        if (pop)
          q_rd_reg <= q_rd_reg + QW'(1);
        count_reg <= count_reg + CW'(push) - CW'(pop);
      end

      if (flush_d_i || (!stall_d_i && pc_source_i)) begin
        instr_reg   <= '0;
        pc_d_reg    <= '0;
        pc_next_reg <= '0;
        valid_reg   <= 1'b0;
      end else if (!stall_d_i) begin
        if (count_reg != '0) begin
          instr_reg   <= q_instr_mem[q_rd_reg];
          pc_d_reg    <= q_pc_mem[q_rd_reg];
          pc_next_reg <= q_pc_mem[q_rd_reg] + 32'd4;
          valid_reg   <= 1'b1;
        end else if (bypass) begin
          instr_reg   <= imem_rdata_i;
          pc_d_reg    <= resp_pc;
          pc_next_reg <= resp_pc + 32'd4;
          valid_reg   <= 1'b1;
        end else begin
          instr_reg   <= '0;
          pc_d_reg    <= '0;
          pc_next_reg <= '0;
          valid_reg   <= 1'b0;
        end
      end
    end
  end

  // Storage arrays carry no reset so they map onto RAM.
  always_ff @(posedge clk_i) begin
    if (grant)
      trk_mem[trk_wr_reg] <= pc_reg;
    if (push) begin
      q_pc_mem[q_wr_reg]    <= resp_pc;
      q_instr_mem[q_wr_reg] <= imem_rdata_i;
    end
  end

  assign instr_o       = instr_reg;
  assign pc_o          = pc_d_reg;
  assign pc_next_o     = pc_next_reg;
  assign instr_valid_o = valid_reg;
  assign fifo_count_o  = count_reg;
endmodule

// File: tb/tb_rv32_fetch_queue.sv
// Directed bench for rv32_fetch_queue: in-order memory model plus per-scenario tasks with hand-derived expectations.
module tb_rv32_fetch_queue;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_source = 1'b0;
  logic [31:0] pc_target = 32'h0;
  logic        stall_f = 1'b0;
  logic        stall_d = 1'b0;
  logic        flush_d = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        instr_valid;
  logic [2:0]  fifo_count;

  int          tests = 0;
  int          fails = 0;
  logic        rv_en = 1'b1;
  logic [31:0] pend [$];

`ifdef RV32_FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  rv32_fetch_queue #(.FIFO_DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(32'h100)) dut (
    .clk_i(clk), .rst_i(rst), .pc_source_i(pc_source), .pc_target_i(pc_target),
    .stall_f_i(stall_f), .stall_d_i(stall_d), .flush_d_i(flush_d),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .instr_o(instr), .pc_o(pc), .pc_next_o(pc_next),
    .instr_valid_o(instr_valid), .fifo_count_o(fifo_count));

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0013;
  endfunction

  // In-order memory: accepted addresses queue up, head answered while rv_en is set.
  always @(posedge clk) begin
    if (rst) begin
      pend.delete();
    end else begin
      if (rvalid) void'(pend.pop_front());
      if (imem_req && gnt) pend.push_back(imem_addr);
    end
    #1;
    rvalid = !rst && rv_en && (pend.size() > 0);
    rdata  = (pend.size() > 0) ? mem_word(pend[0]) : 32'h0;
  end

  task automatic wait_valid(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (instr_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic drain();
    gnt = 1'b0;
    rv_en = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; gnt = 1'b1; rv_en = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_req got %b want 0", imem_req); end
    tests++; if (imem_addr !== 32'h100) begin fails++; $display("FAIL reset_addr got %h want 00000100", imem_addr); end
    tests++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d want 0", fifo_count); end
    tests++; if ({instr, pc, pc_next} !== 96'h0) begin fails++; $display("FAIL reset_decode got %h %h %h want zeros", instr, pc, pc_next); end
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", instr_valid); end
    rst = 1'b0;
    $display("[TB] test_reset done");
  endtask

  task automatic test_stream();
    logic [31:0] exp;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      exp = 32'h100 + 32'(4 * i);
      tests++;
      if (imem_req !== 1'b1 || imem_addr !== exp) begin
        fails++; $display("FAIL stream_issue%0d got req=%b addr=%h want req=1 addr=%h", i, imem_req, imem_addr, exp);
      end
    end
`ifndef RV32_FETCH_BYPASS_EN
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL stream_latency got valid=%b want 0", instr_valid); end
    @(negedge clk);
`endif
    for (int i = 0; i < 8; i++) begin
      exp = 32'h100 + 32'(4 * i);
      tests++;
      if (instr_valid !== 1'b1 || pc !== exp) begin
        fails++; $display("FAIL stream_pc%0d got valid=%b pc=%h want valid=1 pc=%h", i, instr_valid, pc, exp);
      end
      tests++;
      if (instr !== mem_word(exp) || pc_next !== exp + 32'd4) begin
        fails++; $display("FAIL stream_instr%0d got %h/%h want %h/%h", i, instr, pc_next, mem_word(exp), exp + 32'd4);
      end
      @(negedge clk);
    end
    $display("[TB] test_stream done");
  endtask

  task automatic test_stall_d();
    logic [31:0] p;
    tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL stall_pre_valid got %b want 1", instr_valid); end
    p = pc;
    stall_d = 1'b1;
    repeat (8) @(negedge clk);
    tests++; if (fifo_count !== 3'd4) begin fails++; $display("FAIL stall_count got %0d want 4", fifo_count); end
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL stall_req got %b want 0", imem_req); end
    tests++; if (pend.size() != 0) begin fails++; $display("FAIL stall_outstanding got %0d want 0", pend.size()); end
    tests++; if (pc !== p || instr_valid !== 1'b1) begin fails++; $display("FAIL stall_hold got pc=%h want %h", pc, p); end
    stall_d = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      tests++;
      if (instr_valid !== 1'b1 || pc !== p + 32'(4 * i) || instr !== mem_word(p + 32'(4 * i))) begin
        fails++; $display("FAIL stall_release%0d got valid=%b pc=%h want pc=%h", i, instr_valid, pc, p + 32'(4 * i));
      end
    end
    $display("[TB] test_stall_d done");
  endtask

  // Put two requests at target and target+4 in flight with responses held back.
  task automatic setup_two_inflight(input logic [31:0] target);
    drain();
    tests++; if (fifo_count !== 3'd0 || instr_valid !== 1'b0 || pend.size() != 0) begin
      fails++; $display("FAIL drain got count=%0d valid=%b pend=%0d want 0/0/0", fifo_count, instr_valid, pend.size());
    end
    rv_en = 1'b0; gnt = 1'b1; pc_source = 1'b1; pc_target = target;
    #1;
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL redirect_req_suppressed got %b want 0", imem_req); end
    @(negedge clk);
    pc_source = 1'b0;
    #1;
    tests++; if (imem_req !== 1'b1 || imem_addr !== target) begin fails++; $display("FAIL inflight0 got req=%b addr=%h want %h", imem_req, imem_addr, target); end
    @(negedge clk);
    tests++; if (imem_req !== 1'b1 || imem_addr !== target + 32'd4) begin fails++; $display("FAIL inflight1 got req=%b addr=%h want %h", imem_req, imem_addr, target + 32'd4); end
    @(negedge clk);
    tests++; if (imem_req !== 1'b0 || pend.size() != 2) begin fails++; $display("FAIL inflight_limit got req=%b pend=%0d want 0/2", imem_req, pend.size()); end
  endtask

  task automatic test_redirect();
    bit ok;
    setup_two_inflight(32'h10);
    pc_source = 1'b1; pc_target = 32'h200; rv_en = 1'b1;
    @(negedge clk);
    pc_source = 1'b0;
    tests++; if (fifo_count !== 3'd0 || instr_valid !== 1'b0) begin fails++; $display("FAIL redirect_clear got count=%0d valid=%b want 0/0", fifo_count, instr_valid); end
    wait_valid(20, ok);
    tests++; if (!ok || pc !== 32'h200 || instr !== mem_word(32'h200)) begin
      fails++; $display("FAIL redirect_target got ok=%b pc=%h instr=%h want pc=00000200", ok, pc, instr);
    end
    $display("[TB] test_redirect done");
  endtask

  task automatic test_redirect_resp();
    bit ok;
    setup_two_inflight(32'h300);
    rv_en = 1'b1;
    @(negedge clk);
    tests++; if (rvalid !== 1'b1) begin fails++; $display("FAIL resp_in_redirect got rvalid=%b want 1", rvalid); end
    pc_source = 1'b1; pc_target = 32'h400;
    @(negedge clk);
    pc_source = 1'b0;
    wait_valid(20, ok);
    tests++; if (!ok || pc !== 32'h400) begin fails++; $display("FAIL redirect_resp_first got ok=%b pc=%h want 00000400", ok, pc); end
    $display("[TB] test_redirect_resp done");
  endtask

  task automatic test_flush();
    logic [31:0] p;
    @(negedge clk);
    tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL flush_pre_valid got %b want 1", instr_valid); end
    p = pc;
    stall_d = 1'b1;
    repeat (6) @(negedge clk);
    tests++; if (fifo_count !== 3'd4) begin fails++; $display("FAIL flush_fill got %0d want 4", fifo_count); end
    flush_d = 1'b1;
    @(negedge clk);
    tests++; if ({instr, pc, pc_next} !== 96'h0 || instr_valid !== 1'b0) begin
      fails++; $display("FAIL flush_decode got %h %h %h valid=%b want zeros", instr, pc, pc_next, instr_valid);
    end
    tests++; if (fifo_count !== 3'd4) begin fails++; $display("FAIL flush_count got %0d want 4", fifo_count); end
    flush_d = 1'b0; stall_d = 1'b0;
    @(negedge clk);
    tests++; if (instr_valid !== 1'b1 || pc !== p + 32'd4) begin fails++; $display("FAIL flush_resume got pc=%h want %h", pc, p + 32'd4); end
    $display("[TB] test_flush done");
  endtask

  task automatic test_latency();
    int k = -1;
    int v = -1;
    drain();
    pc_source = 1'b1; pc_target = 32'h500; gnt = 1'b1; rv_en = 1'b1;
    @(negedge clk);
    pc_source = 1'b0;
    for (int n = 0; n < 12; n++) begin
      if (rvalid === 1'b1 && k < 0) k = n;
      if (instr_valid === 1'b1 && v < 0) v = n;
      @(negedge clk);
    end
    tests++; if (k < 0 || v < 0 || v - k != LAT) begin fails++; $display("FAIL latency got resp=%0d valid=%0d want diff %0d", k, v, LAT); end
    $display("[TB] test_latency done");
  endtask

  task automatic test_random();
    logic [31:0] exp;
    logic        prev_stall;
    int          delivered = 0;
    stall_d = 1'b0; pc_source = 1'b1; pc_target = 32'h800;
    @(negedge clk);
    pc_source = 1'b0; exp = 32'h800; prev_stall = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (instr_valid === 1'b1 && !prev_stall) begin
        tests++;
        if (pc !== exp || instr !== mem_word(exp) || pc_next !== exp + 32'd4) begin
          fails++; $display("FAIL random_stream got pc=%h instr=%h want pc=%h instr=%h", pc, instr, exp, mem_word(exp));
        end
        exp += 32'd4;
        delivered++;
      end
      gnt     = 1'($urandom_range(0, 1));
      rv_en   = 1'($urandom_range(0, 1));
      stall_f = ($urandom_range(0, 3) == 0);
      stall_d = ($urandom_range(0, 3) == 0);
      prev_stall = stall_d;
    end
    stall_f = 1'b0; stall_d = 1'b0; gnt = 1'b1; rv_en = 1'b1;
    tests++; if (delivered < 40) begin fails++; $display("FAIL random_progress got %0d want >=40", delivered); end
    $display("[TB] test_random done, %0d instructions", delivered);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall_d();
    test_redirect();
    test_redirect_resp();
    test_flush();
    test_latency();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/rv32_fetch_queue.md
# rv32_fetch_queue

Parametrised successor of the two-stage RV32 fetch unit: decouples instruction memory from decode with an in-order request/response handshake, up to MAX_OUTSTANDING in-flight requests, and a FIFO_DEPTH-entry instruction queue. Sits between the program counter logic / instruction memory port and the decode stage. Redirects discard stale in-flight responses by count instead of relying on a fixed one-cycle memory latency.

## Interface
- FIFO_DEPTH, 4: instruction queue entries; power of two, ≥2
- MAX_OUTSTANDING, 2: max accepted-but-unanswered memory requests; 1..FIFO_DEPTH
- RESET_PC, 32'h0000_0000: PC loaded on reset
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous, active-high reset
- pc_source_i  in  1  redirect request, same cycle as pc_target_i
- pc_target_i  in  32  redirect address (word aligned)
- stall_f_i  in  1  inhibit new memory requests
- stall_d_i  in  1  hold decode register
- flush_d_i  in  1  clear decode register
- imem_req_o  out  1  request valid
- imem_addr_o  out  32  request address (= current PC)
- imem_gnt_i  in  1  request accepted this cycle (meaningful only with imem_req_o)
- imem_rvalid_i  in  1  response valid; responses strictly in request order
- imem_rdata_i  in  32  response instruction word
- instr_o, pc_o, pc_next_o  out  32 each  decode register contents
- instr_valid_o  out  1  decode register holds a real instruction
- fifo_count_o  out  $clog2(FIFO_DEPTH+1)  queue occupancy

## Operation
- Issue: imem_req_o = !stall_f_i && !pc_source_i && (outstanding < MAX_OUTSTANDING) && (outstanding + fifo_count < FIFO_DEPTH). Credit rule makes FIFO overflow impossible.
- Grant (req && gnt): PC <= PC+4; push PC into in-flight PC tracker (MAX_OUTSTANDING deep); outstanding++.
- Response (rvalid): pop tracker; outstanding--. If discard_cnt > 0: drop, discard_cnt--. Else push {pc, pc+4, rdata} into queue.
- Redirect (pc_source_i): PC <= pc_target_i; queue cleared (count 0); discard_cnt <= outstanding after this cycle's response, i.e. every request still in flight is dropped; a response arriving in the redirect cycle is also dropped. Grant cannot coincide (req suppressed).
- Decode register, priority: flush_d_i → instr/pc/pc_next = 0, valid 0; else stall_d_i → hold; else queue non-empty → load head, pop, valid 1; else → load zeros, valid 0 (bubble).
- Queue push and pop in the same cycle are both performed; count unchanged.
- Redirect and decode pop in same cycle: pop ignored, queue empty, decode register takes bubble unless flush_d_i.
- Stall_f_i does not affect in-flight responses or queue draining.

## Timing
- Reset (async assert): PC=RESET_PC, imem_req_o=0, outstanding=0, discard_cnt=0, queue empty, fifo_count_o=0, instr_o/pc_o/pc_next_o=0, instr_valid_o=0. First request may assert the cycle after deassertion.
- imem_req_o and imem_addr_o are combinational from registered state plus stall_f_i/pc_source_i.
- Response in cycle k, queue empty, no stall: queued at end of k, instr_o valid in k+2 (k+1 with bypass, see Configuration).
- Full queue: imem_req_o low until a pop frees a credit; request re-asserts the cycle after the pop.
- Reset mid-operation: all in-flight requests forgotten; memory must also be reset by same rst_i.

## Configuration
- RV32_FETCH_BYPASS_EN defined: a non-discarded response arriving with queue empty, decode not stalled/flushed and no redirect loads the decode register directly at end of that cycle (no queue push); instr_o visible next cycle.
- Undefined: every response passes through the queue; one extra cycle latency, behaviour otherwise identical.

## Test plan
- Reset with RESET_PC=0x100, zero-wait memory (gnt=1, rvalid one cycle later): addresses 0x100,0x104,0x108 issued on consecutive cycles; instr_o sequence matches memory, pc_next_o = pc_o+4, instr_valid_o continuous after fill.
- stall_d_i held 8 cycles, FIFO_DEPTH=4: fifo_count_o reaches 4, imem_req_o low, outstanding 0; release → four instructions delivered on four consecutive cycles, no loss, no duplication.
- Two requests in flight (0x10,0x14), redirect to 0x200: both responses dropped, next instr_o has pc_o=0x200, fifo_count_o=0 after redirect cycle.
- Response arriving in redirect cycle: dropped; discard_cnt equals remaining outstanding; no stale instruction reaches decode.
- flush_d_i with stall_d_i and non-empty queue: instr_o=0, instr_valid_o=0, fifo_count_o unchanged.
- Random gnt/rvalid delays with and without RV32_FETCH_BYPASS_EN: instruction stream identical to reference model; bypass build shows one cycle lower latency on empty queue.
